// File: rtl/tx_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one AXI-Stream packet generator.
// Whole frames are forwarded unbroken; illegal-length frames are swallowed.
`timescale 1ns/1ps

module tx_frame_arbiter #(
    parameter int NUM_SRC    = 2,
    parameter int WORD_BYTES = 1,
    parameter int MAX_LEN    = 1472,
    parameter int GAP_CYCLES = 16
) (
    input  logic                            CLK,
    input  logic                            reset_n,
    input  logic [NUM_SRC*WORD_BYTES*8-1:0] S_AXIS_TDATA,
    input  logic [NUM_SRC-1:0]              S_AXIS_TVALID,
    input  logic [NUM_SRC-1:0]              S_AXIS_TLAST,
    input  logic [NUM_SRC*12-1:0]           S_AXIS_TUSER,
    output logic [NUM_SRC-1:0]              S_AXIS_TREADY,
    output logic [WORD_BYTES*8-1:0]         M_AXIS_TDATA,
    output logic                            M_AXIS_TVALID,
    output logic                            M_AXIS_TLAST,
    output logic [11:0]                     M_AXIS_TUSER,
    input  logic                            M_AXIS_TREADY,
    output logic [NUM_SRC-1:0]              GRANT,
    output logic                            DROP_PULSE,
    output logic                            LEN_ERR_PULSE,
    output logic [15:0]                     FRAME_COUNT,
    output logic [15:0]                     DROP_COUNT
);

    localparam int DW       = WORD_BYTES * 8;
    localparam int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [11:0] MAX_LEN_V = 12'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [SRC_W-1:0]   last_src_q, last_src_d;
    logic [SRC_W-1:0]   sel_q, sel_d;
    logic [11:0]        len_q, len_d;
    logic [11:0]        beat_cnt_q, beat_cnt_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic [15:0]        drop_count_q, drop_count_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               drop_pulse_q, drop_pulse_d;
    logic               len_err_pulse_q, len_err_pulse_d;

    logic [DW-1:0]      src_data [NUM_SRC];
    logic [11:0]        src_len  [NUM_SRC];
    logic [SRC_W-1:0]   cand     [NUM_SRC];

    logic               win_valid;
    logic [SRC_W-1:0]   win_idx;
    logic [11:0]        win_len;
    logic [11:0]        beat_inc;
    logic               frame_end;

    // cand[k] is the k-th source in priority order, starting just above last_src.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_data[gi] = S_AXIS_TDATA[gi*DW +: DW];
            assign src_len[gi]  = S_AXIS_TUSER[gi*12 +: 12];
            assign cand[gi]     = SRC_W'((int'(last_src_q) + gi + 1) % NUM_SRC);
        end
    endgenerate

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!win_valid && S_AXIS_TVALID[cand[k]]) begin
                win_valid = 1'b1;
                win_idx   = cand[k];
            end
        end
    end

    assign win_len  = src_len[win_idx];
    // Saturate so an overlong frame can never wrap back onto a matching count.
    assign beat_inc = (beat_cnt_q == 12'hFFF) ? beat_cnt_q : beat_cnt_q + 12'd1;

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_src_d      = last_src_q;
        sel_d           = sel_q;
        len_d           = len_q;
        beat_cnt_d      = beat_cnt_q;
        frame_count_d   = frame_count_q;
        drop_count_d    = drop_count_q;
        gap_cnt_d       = gap_cnt_q;
        drop_pulse_d    = 1'b0;
        len_err_pulse_d = 1'b0;
        frame_end       = 1'b0;
        S_AXIS_TREADY   = '0;
        M_AXIS_TDATA    = '0;
        M_AXIS_TVALID   = 1'b0;
        M_AXIS_TLAST    = 1'b0;
        M_AXIS_TUSER    = '0;

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    last_src_d       = win_idx;
                    sel_d            = win_idx;
                    len_d            = win_len;
                    beat_cnt_d       = '0;
                    if ((win_len == 12'd0) || (win_len > MAX_LEN_V)) begin
                        state_d      = ST_DROP;
                        drop_pulse_d = 1'b1;
                    end else begin
                        state_d = ST_PASS;
                    end
                end
            end

            ST_PASS: begin
                M_AXIS_TDATA         = src_data[sel_q];
                M_AXIS_TVALID        = S_AXIS_TVALID[sel_q];
                M_AXIS_TLAST         = S_AXIS_TLAST[sel_q];
                M_AXIS_TUSER         = len_q;
                S_AXIS_TREADY[sel_q] = M_AXIS_TREADY;
                if (S_AXIS_TVALID[sel_q] && M_AXIS_TREADY) begin
                    beat_cnt_d = beat_inc;
                    if (S_AXIS_TLAST[sel_q]) begin
                        frame_count_d   = frame_count_q + 16'd1;
                        len_err_pulse_d = (beat_inc != len_q);
                        frame_end       = 1'b1;
                    end
                end
            end

            ST_DROP: begin
                S_AXIS_TREADY[sel_q] = 1'b1;
                if (S_AXIS_TVALID[sel_q] && S_AXIS_TLAST[sel_q]) begin
                    drop_count_d = drop_count_q + 16'd1;
                    frame_end    = 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (frame_end) begin
            grant_d = '0;
            if (GAP_CYCLES == 0) begin
                state_d = ST_IDLE;
            end else begin
                state_d   = ST_GAP;
                gap_cnt_d = GAP_W'(GAP_LOAD);
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            grant_q         <= '0;
            last_src_q      <= SRC_W'(NUM_SRC - 1);
            sel_q           <= '0;
            len_q           <= '0;
            beat_cnt_q      <= '0;
            frame_count_q   <= '0;
            drop_count_q    <= '0;
            gap_cnt_q       <= '0;
            drop_pulse_q    <= 1'b0;
            len_err_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            last_src_q      <= last_src_d;
            sel_q           <= sel_d;
            len_q           <= len_d;
            beat_cnt_q      <= beat_cnt_d;
            frame_count_q   <= frame_count_d;
            drop_count_q    <= drop_count_d;
            gap_cnt_q       <= gap_cnt_d;
            drop_pulse_q    <= drop_pulse_d;
            len_err_pulse_q <= len_err_pulse_d;
        end
    end

    assign GRANT         = grant_q;
    assign DROP_PULSE    = drop_pulse_q;
    assign LEN_ERR_PULSE = len_err_pulse_q;
    assign FRAME_COUNT   = frame_count_q;
    assign DROP_COUNT    = drop_count_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: table of single frames plus hand-built
// backpressure, reset-mid-frame and contention sequences.
`timescale 1ns/1ps

module tb_tx_frame_arbiter;

    localparam int NS  = 2;
    localparam int GAP = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] s_tdata;
    logic [1:0]  s_tvalid;
    logic [1:0]  s_tlast;
    logic [23:0] s_tuser;
    logic [1:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic [11:0] m_tuser;
    logic        m_tready;
    logic [1:0]  grant;
    logic        drop_pulse;
    logic        len_err_pulse;
    logic [15:0] frame_count;
    logic [15:0] drop_count;

    tx_frame_arbiter #(
        .NUM_SRC(NS), .WORD_BYTES(1), .MAX_LEN(1472), .GAP_CYCLES(GAP)
    ) dut (
        .CLK(clk), .reset_n(rst_n),
        .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast),
        .S_AXIS_TUSER(s_tuser), .S_AXIS_TREADY(s_tready),
        .M_AXIS_TDATA(m_tdata), .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast),
        .M_AXIS_TUSER(m_tuser), .M_AXIS_TREADY(m_tready),
        .GRANT(grant), .DROP_PULSE(drop_pulse), .LEN_ERR_PULSE(len_err_pulse),
        .FRAME_COUNT(frame_count), .DROP_COUNT(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Edge counter and output monitor
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    logic [7:0]  mon_d[$];
    logic        mon_l[$];
    logic [11:0] mon_u[$];
    int          mon_hs[$];
    logic [1:0]  mon_g[$];
    int          mon_gc[$];
    int          drop_pulses = 0;
    int          lenerr_pulses = 0;
    int          tuser_bad = 0;
    bit          chk_user_en = 0;
    int          exp_user = 0;
    logic [1:0]  prev_grant = '0;

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (m_tvalid && m_tready) begin
                mon_d.push_back(m_tdata);
                mon_l.push_back(m_tlast);
                mon_u.push_back(m_tuser);
                if (m_tlast) mon_hs.push_back(cyc + 1);
            end
            if (drop_pulse) drop_pulses++;
            if (len_err_pulse) lenerr_pulses++;
            if (grant != 2'b00 && prev_grant == 2'b00) begin
                mon_g.push_back(grant);
                mon_gc.push_back(cyc);
            end
            if (chk_user_en && grant != 2'b00 && int'(m_tuser) != exp_user) tuser_bad++;
            prev_grant = grant;
        end else begin
            prev_grant = '0;
        end
    end

    // Per-source frame plans consumed by run_plan
    int pn [NS];
    int pu [NS][4];
    int pb [NS][4];
    int pd [NS][4];
    int start_cyc = 0;

    task automatic run_plan(input bit toggle_ready);
        int idx [NS];
        int beat [NS];
        bit hs [NS];
        bit busy;
        bit started;
        for (int s = 0; s < NS; s++) begin
            idx[s] = 0; beat[s] = 0; hs[s] = 0;
        end
        started = 0;
        busy = 1;
        @(posedge clk); #1;
        for (int c = 0; c < 4000 && busy; c++) begin
            busy = 0;
            for (int s = 0; s < NS; s++) begin
                if (idx[s] < pn[s]) begin
                    busy = 1;
                    s_tvalid[s]         = 1'b1;
                    s_tuser[s*12 +: 12] = 12'(pu[s][idx[s]]);
                    s_tdata[s*8 +: 8]   = 8'(pb[s][idx[s]] + beat[s]);
                    s_tlast[s]          = (beat[s] == pd[s][idx[s]] - 1);
                end else begin
                    s_tvalid[s] = 1'b0;
                    s_tlast[s]  = 1'b0;
                end
            end
            if (busy) begin
                if (!started) begin
                    started = 1;
                    start_cyc = cyc;
                end
                m_tready = toggle_ready ? (c % 2 == 0) : 1'b1;
                @(negedge clk);
                for (int s = 0; s < NS; s++) hs[s] = s_tvalid[s] && s_tready[s];
                @(posedge clk); #1;
                for (int s = 0; s < NS; s++) begin
                    if (hs[s]) begin
                        beat[s]++;
                        if (beat[s] == pd[s][idx[s]]) begin
                            idx[s]++;
                            beat[s] = 0;
                        end
                    end
                end
            end
        end
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        chk("plan_timeout", int'(busy), 0);
    endtask

    typedef struct {
        int src;
        int user;
        int beats;
        int base;
        bit drop;
        bit err;
    } vec_t;

    localparam int NV = 7;
    vec_t vt [NV];
    int exp_frames = 0;
    int exp_drops  = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, gmark, hmark, d0, e0, b0, got, fwd;
        int exp_src [4];
        int exp_base [4];

        vt[0] = '{0, 5,    5,    8'h10, 1'b0, 1'b0};
        vt[1] = '{1, 0,    2,    8'h20, 1'b1, 1'b0};
        vt[2] = '{1, 1473, 3,    8'h30, 1'b1, 1'b0};
        vt[3] = '{0, 4,    3,    8'h40, 1'b0, 1'b1};
        vt[4] = '{1, 1,    1,    8'h50, 1'b0, 1'b0};
        vt[5] = '{0, 2,    3,    8'h60, 1'b0, 1'b1};
        vt[6] = '{1, 1472, 1472, 8'h80, 1'b0, 1'b0};

        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tuser  = '0;
        m_tready = 1'b1;
        for (int s = 0; s < NS; s++) pn[s] = 0;

        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_muser", m_tuser, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_drop_pulse", drop_pulse, 0);
        chk("rst_len_err", len_err_pulse, 0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            for (int s = 0; s < NS; s++) pn[s] = 0;
            pn[vt[i].src]    = 1;
            pu[vt[i].src][0] = vt[i].user;
            pb[vt[i].src][0] = vt[i].base;
            pd[vt[i].src][0] = vt[i].beats;
            mark  = mon_d.size();
            gmark = mon_g.size();
            d0    = drop_pulses;
            e0    = lenerr_pulses;
            run_plan(1'b0);
            repeat (GAP + 3) @(posedge clk);
            @(negedge clk);
            fwd = vt[i].drop ? 0 : vt[i].beats;
            got = mon_d.size() - mark;
            chk($sformatf("v%0d_beats", i), got, fwd);
            for (int b = 0; b < fwd && b < got; b++) begin
                chk($sformatf("v%0d_data%0d", i, b), mon_d[mark+b], (vt[i].base + b) % 256);
                chk($sformatf("v%0d_last%0d", i, b), mon_l[mark+b], int'(b == fwd - 1));
                chk($sformatf("v%0d_user%0d", i, b), mon_u[mark+b], vt[i].user);
            end
            chk($sformatf("v%0d_grants", i), mon_g.size() - gmark, 1);
            if (mon_g.size() > gmark) begin
                chk($sformatf("v%0d_grant", i), mon_g[gmark], 1 << vt[i].src);
                if (i == 0) chk("v0_grant_latency", mon_gc[gmark] - start_cyc, 1);
            end
            chk($sformatf("v%0d_drop_pulse", i), drop_pulses - d0, int'(vt[i].drop));
            chk($sformatf("v%0d_len_err", i), lenerr_pulses - e0, int'(vt[i].err));
            if (vt[i].drop) exp_drops++;
            else exp_frames++;
            chk($sformatf("v%0d_frame_count", i), frame_count, exp_frames);
            chk($sformatf("v%0d_drop_count", i), drop_count, exp_drops);
            chk($sformatf("v%0d_grant_clear", i), grant, 0);
        end

        // Backpressure: ready toggles every cycle across a 6-beat frame
        for (int s = 0; s < NS; s++) pn[s] = 0;
        pn[0] = 1; pu[0][0] = 6; pb[0][0] = 8'hC0; pd[0][0] = 6;
        mark = mon_d.size();
        b0 = tuser_bad;
        exp_user = 6;
        chk_user_en = 1;
        run_plan(1'b1);
        chk_user_en = 0;
        repeat (GAP + 3) @(posedge clk);
        @(negedge clk);
        got = mon_d.size() - mark;
        chk("bp_beats", got, 6);
        for (int b = 0; b < 6 && b < got; b++) begin
            chk($sformatf("bp_data%0d", b), mon_d[mark+b], 8'hC0 + b);
            chk($sformatf("bp_last%0d", b), mon_l[mark+b], int'(b == 5));
        end
        chk("bp_tuser_stable", tuser_bad - b0, 0);
        exp_frames++;
        chk("bp_frame_count", frame_count, exp_frames);

        // Reset asserted while beat 2 of a frame is on the bus
        @(posedge clk); #1;
        s_tvalid[0]    = 1'b1;
        s_tuser[11:0]  = 12'd5;
        s_tdata[7:0]   = 8'h70;
        s_tlast[0]     = 1'b0;
        m_tready       = 1'b1;
        @(posedge clk); #1;
        chk("rm_grant_before", grant, 1);
        @(posedge clk); #1;
        s_tdata[7:0] = 8'h71;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_grant", grant, 0);
        chk("rm_tready", s_tready, 0);
        chk("rm_mvalid", m_tvalid, 0);
        chk("rm_frame_count", frame_count, 0);
        chk("rm_drop_count", drop_count, 0);
        s_tvalid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_frames = 0;
        exp_drops  = 0;

        // Contention straight after reset: src0 must win first, then alternate
        pn[0] = 2; pn[1] = 2;
        pu[0][0] = 3; pb[0][0] = 8'hA0; pd[0][0] = 3;
        pu[0][1] = 3; pb[0][1] = 8'hA8; pd[0][1] = 3;
        pu[1][0] = 3; pb[1][0] = 8'hB0; pd[1][0] = 3;
        pu[1][1] = 3; pb[1][1] = 8'hB8; pd[1][1] = 3;
        exp_src[0] = 0; exp_base[0] = 8'hA0;
        exp_src[1] = 1; exp_base[1] = 8'hB0;
        exp_src[2] = 0; exp_base[2] = 8'hA8;
        exp_src[3] = 1; exp_base[3] = 8'hB8;
        mark  = mon_d.size();
        gmark = mon_g.size();
        hmark = mon_hs.size();
        run_plan(1'b0);
        repeat (GAP + 3) @(posedge clk);
        @(negedge clk);
        got = mon_d.size() - mark;
        chk("ct_beats", got, 12);
        for (int f = 0; f < 4; f++) begin
            for (int b = 0; b < 3; b++) begin
                if (f * 3 + b < got)
                    chk($sformatf("ct_f%0d_data%0d", f, b), mon_d[mark + f*3 + b], exp_base[f] + b);
            end
        end
        chk("ct_grants", mon_g.size() - gmark, 4);
        for (int f = 0; f < 4; f++) begin
            if (gmark + f < mon_g.size())
                chk($sformatf("ct_grant%0d", f), mon_g[gmark+f], 1 << exp_src[f]);
        end
        for (int f = 0; f < 3; f++) begin
            if (gmark + f + 1 < mon_gc.size() && hmark + f < mon_hs.size())
                chk($sformatf("ct_spacing%0d", f), mon_gc[gmark+f+1] - mon_hs[hmark+f], GAP + 1);
        end
        exp_frames += 4;
        chk("ct_frame_count", frame_count, exp_frames);
        chk("ct_drop_count", drop_count, exp_drops);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Round-robin, frame-granular arbiter that shares the single UDP/RMII packet generator between `NUM_SRC` AXI-Stream payload sources, such as the GPIO string source and a status reporter.

- Sits directly upstream of the generator's `S_AXIS_*` port.
- Grants one source at a time and forwards its whole frame unbroken.
- Holds the frame length on `M_AXIS_TUSER` stable for the entire frame.
- Discards frames whose declared length is illegal.
- Enforces a programmable idle gap between frames so the generator can drain.

## Interface

Parameters
- `NUM_SRC`, default 2: number of requesting sources, 2..8.
- `WORD_BYTES`, default 1: bytes per stream beat.
- `MAX_LEN`, default 1472: largest legal payload length in beats; must be less than 4096.
- `GAP_CYCLES`, default 16: idle cycles inserted after each forwarded or dropped frame; 0 is allowed.

Ports
- `CLK`  in  1: single clock; all logic is rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `S_AXIS_TDATA`  in  NUM_SRC*WORD_BYTES*8: per-source data; source i occupies slice i.
- `S_AXIS_TVALID`  in  NUM_SRC: per-source valid.
- `S_AXIS_TLAST`  in  NUM_SRC: per-source last beat.
- `S_AXIS_TUSER`  in  NUM_SRC*12: per-source payload length in beats; must be valid whenever TVALID is high.
- `S_AXIS_TREADY`  out  NUM_SRC: per-source ready.
- `M_AXIS_TDATA`  out  WORD_BYTES*8: data to the generator.
- `M_AXIS_TVALID`  out  1: valid to the generator.
- `M_AXIS_TLAST`  out  1: last beat to the generator.
- `M_AXIS_TUSER`  out  12: latched length of the current frame.
- `M_AXIS_TREADY`  in  1: ready from the generator.
- `GRANT`  out  NUM_SRC: registered one-hot grant; all zero when no source is granted.
- `DROP_PULSE`  out  1: one-cycle pulse when a frame is rejected.
- `LEN_ERR_PULSE`  out  1: one-cycle pulse when a forwarded frame's beat count differs from its TUSER.
- `FRAME_COUNT`  out  16: count of forwarded frames; wraps modulo 2^16.
- `DROP_COUNT`  out  16: count of dropped frames; wraps modulo 2^16.

## Operation

States: IDLE, PASS, DROP, GAP.

- **IDLE**
  - With any `S_AXIS_TVALID` bit high, pick the winner by searching upward from `last_src+1`, wrapping at `NUM_SRC`.
  - On that edge, register the winner into `GRANT`, `last_src` and `sel`, and latch its TUSER into `len_q`.
  - If `len_q` would be 0 or greater than `MAX_LEN`: go to DROP and pulse `DROP_PULSE` on the same edge.
  - Otherwise go to PASS.
  - With no `S_AXIS_TVALID` bit high, remain in IDLE.
- **PASS**
  - Combinational pass-through: `M_AXIS_TDATA`, `M_AXIS_TVALID` and `M_AXIS_TLAST` come from source `sel`.
  - `S_AXIS_TREADY[sel]` = `M_AXIS_TREADY`; every other ready bit is 0.
  - `M_AXIS_TUSER` = `len_q`.
  - `beat_cnt` increments on each handshake.
  - On a handshake with TLAST: increment `FRAME_COUNT`; pulse `LEN_ERR_PULSE` if `beat_cnt+1` ≠ `len_q`; leave PASS.
- **DROP**
  - `S_AXIS_TREADY[sel]` = 1 and `M_AXIS_TVALID` = 0.
  - Accepts and discards beats until a handshake with TLAST, then increments `DROP_COUNT` and leaves DROP.
- **Leaving PASS or DROP:** clear `GRANT` and go to GAP, or straight to IDLE when `GAP_CYCLES` = 0.
- **GAP:** counts `GAP_CYCLES` cycles with all readies 0 and `M_AXIS_TVALID` = 0, then returns to IDLE.
- **Outside PASS:** `M_AXIS_*` data, last and user outputs are 0.
- **Fairness:** a source that still has TVALID high after its frame ends is not re-granted while any other source is requesting.

## Timing

- **Reset values:**
  - State = IDLE.
  - `GRANT` = 0.
  - `last_src` = NUM_SRC-1, so source 0 has first priority.
  - `len_q`, `beat_cnt`, `FRAME_COUNT`, `DROP_COUNT` = 0.
  - Pulses = 0, all `S_AXIS_TREADY` = 0, `M_AXIS_TVALID` = 0.
- **Grant latency:** a request seen in IDLE on edge n gives `M_AXIS_TVALID` high in the cycle after edge n.
  - No source beat is accepted in the IDLE cycle itself.
- **Throughput in PASS:** one beat per cycle, with zero added latency.
  - `M_AXIS_TREADY` low simply stalls; no data is buffered.
- **Frame spacing:** minimum cycles from one frame's TLAST handshake to the next grant edge = `GAP_CYCLES` + 1.
- **TUSER:** `M_AXIS_TUSER` is constant from the grant edge until the cycle after the TLAST handshake.
- **Simultaneous requests:** resolved purely by the rotating priority; requests arriving during PASS, DROP or GAP wait.
- **Source drops TVALID mid-frame:** the grant is held and PASS never times out.
- **Reset mid-frame:** asynchronous return to reset values; a truncated frame is not counted and not reported.
- **Counter wrap:** `FRAME_COUNT` and `DROP_COUNT` roll 0xFFFF → 0x0000 with no flag.

## Test plan

- **Single frame:** reset; src0 sends 5 beats with TUSER = 5 and `M_AXIS_TREADY` = 1 → `GRANT` = 01 one cycle later, 5 beats forwarded in order, TLAST on beat 5, `FRAME_COUNT` = 1, no error pulse.
- **Contention:** src0 and src1 request together, 3-beat frames, `GAP_CYCLES` = 4 → order src0, src1, src0, src1; exactly 5 idle cycles between each TLAST handshake and the next grant edge.
- **Illegal lengths:** src1 sends TUSER = 0, then separately TUSER = 1473 → each frame consumed with `M_AXIS_TVALID` = 0, `DROP_PULSE` once per frame, `DROP_COUNT` = 2.
- **Length mismatch:** TUSER = 4 but TLAST on beat 3 → 3 beats forwarded, `LEN_ERR_PULSE` for one cycle, `FRAME_COUNT` incremented.
- **Backpressure:** toggle `M_AXIS_TREADY` 1-0-1-0 across a 6-beat frame → no beat lost or duplicated; `M_AXIS_TUSER` stays 6 throughout.
- **Reset mid-frame:** assert `reset_n` low during beat 2 → `GRANT` = 0 and `S_AXIS_TREADY` = 0 immediately; counters at 0; the next frame from src0 is granted normally.
